// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
//   APB completer holding a bank of DEPTH read/write registers. It inserts
//   a programmable number of wait states per transfer. Out-of-range
//   addresses get an error response and are tallied in a saturating
//   error counter.
//
// Ports
//   i_PCLK          APB clock, rising-edge active
//   i_PRESETn       asynchronous active-low reset
//   i_PSEL          slave select
//   i_PENABLE       access-phase indicator
//   i_PWRITE        1 = write, 0 = read (sampled in the completing cycle)
//   i_PADDR         word address (sampled in the completing cycle)
//   i_PWDATA        write data (sampled in the completing cycle)
//   i_wait_cycles   wait states per transfer, sampled in the setup phase
//   o_PREADY        transfer complete
//   o_PRDATA        read data, non-zero only on a good completing read
//   o_PSLVERR       error response, only while o_PREADY is high
//   o_err_count     saturating count of errored transfers
module apb_slave_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic              i_PCLK,
  input  logic              i_PRESETn,
  input  logic              i_PSEL,
  input  logic              i_PENABLE,
  input  logic              i_PWRITE,
  input  logic [ADDR_W-1:0] i_PADDR,
  input  logic [DATA_W-1:0] i_PWDATA,
  input  logic [WAIT_W-1:0] i_wait_cycles,
  output logic              o_PREADY,
  output logic [DATA_W-1:0] o_PRDATA,
  output logic              o_PSLVERR,
  output logic [ERR_W-1:0]  o_err_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0]  errCount_q, errCount_d;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic              addrErr;
  logic              ready;
  logic              wrEn;
  logic [IDX_W-1:0]  idx;

  // Range check is done on a 32-bit zero-extended copy so the compare
  // against DEPTH is width-exact whatever ADDR_W is. The register index
  // is only ever used when addrErr is low.
  always_comb begin
    addrErr = ({{(32-ADDR_W){1'b0}}, i_PADDR} >= 32'(DEPTH));
    idx     = i_PADDR[IDX_W-1:0];
  end

  // Completion is purely combinational, so a zero-wait transfer finishes
  // in its first access cycle and the outputs drop the instant reset hits.
  always_comb begin
    ready     = (state_q == ACCESS) && i_PSEL && i_PENABLE && (cnt_q == '0);
    wrEn      = ready && i_PWRITE && !addrErr;
    o_PREADY  = ready;
    o_PSLVERR = ready && addrErr;
    o_PRDATA  = '0;
    if (ready && !i_PWRITE && !addrErr) begin
      o_PRDATA = regs_q[idx];
    end
    o_err_count = errCount_q;
  end

  // Next-state logic. A setup phase seen while already in ACCESS restarts
  // the wait count rather than going back through IDLE. Dropping PSEL
  // mid-transfer abandons it with no side effects.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    errCount_d = errCount_q;
    unique case (state_q)
      IDLE: begin
        if (i_PSEL && !i_PENABLE) begin
          state_d = ACCESS;
          cnt_d   = i_wait_cycles;
        end
      end
      ACCESS: begin
        if (!i_PSEL) begin
          state_d = IDLE;
        end else if (!i_PENABLE) begin
          cnt_d = i_wait_cycles;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ready && addrErr && (errCount_q != '1)) begin
      errCount_d = errCount_q + 1'b1;
    end
  end

  // Control state and error counter.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      errCount_q <= errCount_d;
    end
  end

  // Register bank: written only on a good completing write.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrEn) begin
      regs_q[idx] <= i_PWDATA;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile
//   Directed bench for apb_slave_regfile. Inputs change 1 ns after a rising
//   edge. Outputs are sampled on the falling edge, or at an explicit offset
//   around the asynchronous reset.
module tb_apb_slave_regfile;

  logic       pClk;
  logic       pResetN;
  logic       pSel;
  logic       pEnable;
  logic       pWrite;
  logic [7:0] pAddr;
  logic [7:0] pWdata;
  logic [3:0] waitCycles;
  logic       pReady;
  logic [7:0] pRdata;
  logic       pSlvErr;
  logic [7:0] errCount;

  int assertCount = 0;
  int failCount   = 0;

  apb_slave_regfile #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(16), .WAIT_W(4), .ERR_W(8)
  ) dut (
    .i_PCLK       (pClk),
    .i_PRESETn    (pResetN),
    .i_PSEL       (pSel),
    .i_PENABLE    (pEnable),
    .i_PWRITE     (pWrite),
    .i_PADDR      (pAddr),
    .i_PWDATA     (pWdata),
    .i_wait_cycles(waitCycles),
    .o_PREADY     (pReady),
    .o_PRDATA     (pRdata),
    .o_PSLVERR    (pSlvErr),
    .o_err_count  (errCount)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                               input logic [7:0] addr, input logic [7:0] wdata);
    pSel    = sel;
    pEnable = en;
    pWrite  = wr;
    pAddr   = addr;
    pWdata  = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full transfer: setup (with junk address/data, which must be ignored),
  // `waits` stalled access cycles, then the completing cycle. The wait-state
  // input is scrambled after setup, which must have no effect. The task
  // returns 1 ns after the completing edge so transfers chain back-to-back.
  task automatic apbXfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [3:0] waits, input logic expErr,
                         input logic [7:0] expRdata, input string tag);
    waitCycles = waits;
    applyStimulus(1'b1, 1'b0, wr, 8'hEE, ~wdata);
    @(negedge pClk);
    checkOutput({tag, "/setupReady"}, pReady, 0);
    @(posedge pClk); #1;
    waitCycles = ~waits;
    applyStimulus(1'b1, 1'b1, wr, addr, wdata);
    for (int k = 0; k < int'(waits); k++) begin
      @(negedge pClk);
      checkOutput({tag, "/waitReady"}, pReady, 0);
      @(posedge pClk); #1;
    end
    @(negedge pClk);
    checkOutput({tag, "/ready"}, pReady, 1);
    checkOutput({tag, "/slvErr"}, pSlvErr, expErr);
    checkOutput({tag, "/rdata"}, pRdata, wr ? 8'h00 : expRdata);
    @(posedge pClk); #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge pClk); #1;
  endtask

  initial begin
    pResetN    = 1'b0;
    waitCycles = 4'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge pClk);
    #1;
    checkOutput("reset/ready", pReady, 0);
    checkOutput("reset/rdata", pRdata, 0);
    checkOutput("reset/slvErr", pSlvErr, 0);
    checkOutput("reset/errCount", errCount, 0);
    pResetN = 1'b1;
    @(posedge pClk); #1;

    $display("[TB] basic write/read");
    apbXfer(1'b1, 8'd3, 8'hA5, 4'd0, 1'b0, 8'h00, "wr3");
    apbXfer(1'b0, 8'd3, 8'h00, 4'd0, 1'b0, 8'hA5, "rd3");
    apbXfer(1'b0, 8'd4, 8'h00, 4'd0, 1'b0, 8'h00, "rd4");
    idleCycle();

    $display("[TB] wait states");
    apbXfer(1'b1, 8'd7, 8'h3C, 4'd3, 1'b0, 8'h00, "wr7w3");
    apbXfer(1'b0, 8'd7, 8'h00, 4'd0, 1'b0, 8'h3C, "rd7");
    idleCycle();

    $display("[TB] address errors");
    apbXfer(1'b1, 8'd16, 8'hFF, 4'd0, 1'b1, 8'h00, "errWr16");
    checkOutput("errWr16/errCount", errCount, 1);
    apbXfer(1'b0, 8'd0, 8'h00, 4'd0, 1'b0, 8'h00, "rd0AfterErr");
    apbXfer(1'b0, 8'd200, 8'h00, 4'd1, 1'b1, 8'h00, "errRd200");
    checkOutput("errRd200/errCount", errCount, 2);
    for (int i = 0; i < 253; i++) begin
      apbXfer(1'b0, 8'hF0, 8'h00, 4'd0, 1'b1, 8'h00, "errLoop");
    end
    checkOutput("errCount255", errCount, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      apbXfer(1'b1, 8'hFF, 8'h77, 4'd0, 1'b1, 8'h00, "errSat");
    end
    checkOutput("errCountSat", errCount, 8'hFF);
    idleCycle();

    $display("[TB] abort");
    apbXfer(1'b1, 8'd2, 8'h22, 4'd0, 1'b0, 8'h00, "wr2");
    waitCycles = 4'd5;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 8'h11);
    @(posedge pClk); #1;
    waitCycles = 4'd0;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd2, 8'h11);
    for (int k = 0; k < 2; k++) begin
      @(negedge pClk);
      checkOutput("abort/waitReady", pReady, 0);
      @(posedge pClk); #1;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd2, 8'h11);
    @(negedge pClk);
    checkOutput("abort/dropReady", pReady, 0);
    @(posedge pClk); #1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd2, 8'h11);
    for (int k = 0; k < 5; k++) begin
      @(negedge pClk);
      checkOutput("abort/noSetupReady", pReady, 0);
      @(posedge pClk); #1;
    end
    idleCycle();
    apbXfer(1'b0, 8'd2, 8'h00, 4'd0, 1'b0, 8'h22, "abort/rd2");
    checkOutput("abort/errCount", errCount, 8'hFF);
    idleCycle();

    $display("[TB] back-to-back");
    for (int a = 0; a < 16; a++) begin
      apbXfer(1'b1, 8'(a), 8'(8'h10 + a), 4'd0, 1'b0, 8'h00, "b2bWr");
    end
    for (int a = 0; a < 16; a++) begin
      apbXfer(1'b0, 8'(a), 8'h00, 4'd0, 1'b0, 8'(8'h10 + a), "b2bRd");
    end
    apbXfer(1'b1, 8'd9, 8'h5A, 4'd0, 1'b0, 8'h00, "wr9");
    apbXfer(1'b0, 8'd9, 8'h00, 4'd0, 1'b0, 8'h5A, "rd9Immediate");

    $display("[TB] async reset mid-transfer");
    waitCycles = 4'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE, 8'h00);
    @(posedge pClk); #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd5, 8'h00);
    @(negedge pClk);
    checkOutput("rst/waitReady", pReady, 0);
    @(posedge pClk); #1;
    @(negedge pClk);
    checkOutput("rst/preReady", pReady, 1);
    checkOutput("rst/preRdata", pRdata, 8'h15);
    #2;
    pResetN = 1'b0;
    #1;
    checkOutput("rst/readyDrop", pReady, 0);
    checkOutput("rst/rdataDrop", pRdata, 0);
    checkOutput("rst/errCountDrop", errCount, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge pClk); #1;
    pResetN = 1'b1;
    @(posedge pClk); #1;
    for (int a = 0; a < 16; a++) begin
      apbXfer(1'b0, 8'(a), 8'h00, 4'd0, 1'b0, 8'h00, "rstRd");
    end
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
